// File: rtl/fir_pkg.sv
// Shared widths, FSM encoding and output rounding/saturation for the TDM FIR.
package fir_pkg;

    // Working width for the generic rounding helper; wide enough for any accumulator.
    localparam int unsigned RS_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } fir_state_e;

    typedef struct packed {
        logic signed [RS_W-1:0] data;
        logic                   sat;
    } rs_result_t;

    // Index width for n entries, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Accumulator width: a full product plus enough guard bits to sum every tap.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned cw,
                                              input int unsigned taps);
        return dw + cw + $clog2(taps);
    endfunction

    // Largest positive Q1.(cw-1) value, used as c[0] so reset behaves as pass-through.
    function automatic logic [RS_W-1:0] coef_unity(input int unsigned cw);
        return (RS_W'(1) << (cw - 1)) - RS_W'(1);
    endfunction

    // Round half-up, arithmetic shift, then clip to a signed out_w-bit range.
    function automatic rs_result_t round_sat(input logic signed [RS_W-1:0] acc,
                                             input int unsigned shift,
                                             input int unsigned out_w);
        rs_result_t             res;
        logic signed [RS_W-1:0] r;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        if (shift == 0) begin
            r = acc;
        end else begin
            r = (acc + (RS_W'(1) <<< (shift - 1))) >>> shift;
        end
        hi = (RS_W'(1) <<< (out_w - 1)) - RS_W'(1);
        lo = -hi - RS_W'(1);
        res.data = r;
        res.sat  = 1'b0;
        if (r > hi) begin
            res.data = hi;
            res.sat  = 1'b1;
        end else if (r < lo) begin
            res.data = lo;
            res.sat  = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate register with synchronous clear; kept alone to map onto a DSP slice.
module fir_mac_unit #(
    parameter int unsigned A_W   = 16,
    parameter int unsigned B_W   = 16,
    parameter int unsigned ACC_W = 37
) (
    input  logic                    aud_bclk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [A_W+B_W-1:0] prod_c;

    // Full-precision product, sign-extended into the accumulator.
    assign prod_c = a * b;

    // Accumulator: clear wins over enable.
    always_ff @(posedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod_c);
        end
    end

endmodule

// File: rtl/fir_tdm_filter.sv
// Time-multiplexed multi-channel FIR: one MAC iterates over TAPS run-time coefficients per sample.
module fir_tdm_filter
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned COEF_W   = 16,
    parameter int unsigned TAPS     = 32,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned OUT_W    = 16,
    parameter int unsigned SHIFT    = 15
) (
    input  logic                                aud_bclk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    input  logic [clog2_min1(CHANNELS)-1:0]     in_ch,
    input  logic signed [DATA_W-1:0]            in_data,
    output logic                                in_ready,
    input  logic                                coef_we,
    input  logic [clog2_min1(TAPS)-1:0]         coef_addr,
    input  logic signed [COEF_W-1:0]            coef_wdata,
    output logic                                coef_ack,
    output logic                                out_valid,
    output logic [clog2_min1(CHANNELS)-1:0]     out_ch,
    output logic signed [OUT_W-1:0]             out_data,
    output logic                                out_sat,
    output logic                                overrun
);

    localparam int unsigned CH_W  = clog2_min1(CHANNELS);
    localparam int unsigned TAP_W = clog2_min1(TAPS);
    localparam int unsigned ACC_W = acc_width(DATA_W, COEF_W, TAPS);

    fir_state_e               state;
    logic signed [DATA_W-1:0] hist [CHANNELS][TAPS];
    logic [TAP_W-1:0]         wptr [CHANNELS];
    logic signed [COEF_W-1:0] coef [TAPS];
    logic [TAP_W-1:0]         newest_q;
    logic [TAP_W-1:0]         k_q;
    logic [CH_W-1:0]          ch_q;
    logic signed [ACC_W-1:0]  acc;

    logic                     accept_c;
    logic                     coef_wr_c;
    logic                     mac_en_c;
    logic [CH_W-1:0]          in_ch_sel_c;
    logic [TAP_W-1:0]         rd_idx_c;
    logic signed [DATA_W-1:0] mac_a_c;
    logic signed [COEF_W-1:0] mac_b_c;
    rs_result_t               rs_c;
    logic                     unused_rs_hi;

    // Handshake decode: samples are taken only in IDLE; coefficient writes lose to a sample.
    always_comb begin
        in_ch_sel_c = (32'(in_ch) < CHANNELS) ? in_ch : '0;
        accept_c    = (state == ST_IDLE) && in_valid;
        coef_wr_c   = (state == ST_IDLE) && !in_valid && coef_we && (32'(coef_addr) < TAPS);
        mac_en_c    = (state == ST_MAC);
    end

    // Circular read index newest-k, wrapped by compare/subtract so TAPS need not be a power of two.
    always_comb begin
        if (k_q <= newest_q) begin
            rd_idx_c = newest_q - k_q;
        end else begin
            rd_idx_c = TAP_W'(32'(newest_q) + TAPS - 32'(k_q));
        end
        mac_a_c = hist[ch_q][rd_idx_c];
        mac_b_c = coef[k_q];
    end

    // Final scaling of the accumulated sum.
    always_comb begin
        rs_c         = round_sat(RS_W'(acc), SHIFT, OUT_W);
        unused_rs_hi = ^rs_c.data[RS_W-1:OUT_W];
    end

    fir_mac_unit #(
        .A_W   (DATA_W),
        .B_W   (COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .aud_bclk (aud_bclk),
        .rst_n    (rst_n),
        .clr      (accept_c),
        .en       (mac_en_c),
        .a        (mac_a_c),
        .b        (mac_b_c),
        .acc      (acc)
    );

    // Per-channel sample history and write pointers.
    always_ff @(posedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                wptr[c] <= '0;
                for (int t = 0; t < int'(TAPS); t++) begin
                    hist[c][t] <= '0;
                end
            end
        end else if (accept_c) begin
            hist[in_ch_sel_c][wptr[in_ch_sel_c]] <= in_data;
            wptr[in_ch_sel_c] <= (32'(wptr[in_ch_sel_c]) == TAPS - 1) ? '0
                                 : wptr[in_ch_sel_c] + TAP_W'(1);
        end
    end

    // Coefficient table with write acknowledge.
    always_ff @(posedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < int'(TAPS); t++) begin
                coef[t] <= '0;
            end
            coef[0]  <= COEF_W'(coef_unity(COEF_W));
            coef_ack <= 1'b0;
        end else begin
            coef_ack <= coef_wr_c;
            if (coef_wr_c) begin
                coef[coef_addr] <= coef_wdata;
            end
        end
    end

    // Sequencer: accept, TAPS MAC cycles, then publish the rounded result.
    always_ff @(posedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ch_q      <= '0;
            newest_q  <= '0;
            k_q       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            overrun   <= in_valid && !in_ready;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        ch_q     <= in_ch_sel_c;
                        newest_q <= wptr[in_ch_sel_c];
                        k_q      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (32'(k_q) == TAPS - 1) begin
                        state <= ST_DONE;
                    end else begin
                        k_q <= k_q + TAP_W'(1);
                    end
                end
                ST_DONE: begin
                    out_valid <= 1'b1;
                    out_data  <= OUT_W'(rs_c.data);
                    out_ch    <= ch_q;
                    out_sat   <= rs_c.sat;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tdm_filter.sv
// Scoreboard bench for fir_tdm_filter with default parameters (TAPS=32, 16-bit data/coefs).
module tb_fir_tdm_filter;

    localparam int unsigned TAPS = 32;

    logic        aud_bclk;
    logic        rst_n;
    logic        in_valid;
    logic [0:0]  in_ch;
    logic [15:0] in_data;
    logic        in_ready;
    logic        coef_we;
    logic [4:0]  coef_addr;
    logic [15:0] coef_wdata;
    logic        coef_ack;
    logic        out_valid;
    logic [0:0]  out_ch;
    logic [15:0] out_data;
    logic        out_sat;
    logic        overrun;

    typedef struct {
        logic [15:0] data;
        logic        ch;
        logic        sat;
        int unsigned acc_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    fir_tdm_filter dut (
        .aud_bclk   (aud_bclk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ch      (in_ch),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_ack   (coef_ack),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .overrun    (overrun)
    );

    initial aud_bclk = 1'b0;
    always #5 aud_bclk = ~aud_bclk;

    always @(posedge aud_bclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every result must match the oldest expectation; latency measured from accept edge.
    // A result registered at edge accept+TAPS+1 is what the edge accept+TAPS+2 samples.
    always @(negedge aud_bclk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual data=%h ch=%0d, required none", out_data, out_ch);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_ch", 32'(out_ch), 32'(e.ch));
                chk("out_sat", 32'(out_sat), 32'(e.sat));
                chk("latency", cyc - e.acc_cyc, TAPS + 1);
            end
        end
    end

    task automatic send(input logic ch, input logic [15:0] d, input bit expect_out,
                        input logic [15:0] ed, input logic es);
        int unsigned guard = 0;
        exp_t        e;
        while (!in_ready && guard < 200) begin
            @(posedge aud_bclk); #1;
            guard++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual in_ready=0 required 1");
        end
        in_valid = 1'b1;
        in_ch    = ch;
        in_data  = d;
        @(posedge aud_bclk); #1;
        in_valid = 1'b0;
        if (expect_out) begin
            e.data    = ed;
            e.ch      = ch;
            e.sat     = es;
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int unsigned guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge aud_bclk); #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic write_coef(input logic [4:0] a, input logic [15:0] d);
        int unsigned guard = 0;
        logic        acked = 1'b0;
        while (!acked && guard < 100) begin
            coef_we    = 1'b1;
            coef_addr  = a;
            coef_wdata = d;
            @(posedge aud_bclk); #1;
            coef_we = 1'b0;
            acked   = coef_ack;
            guard++;
        end
        chk("coef_ack", 32'(acked), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge aud_bclk);
        #1;
        rst_n = 1'b1;
        @(posedge aud_bclk); #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_ch      = '0;
        in_data    = '0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        repeat (2) @(posedge aud_bclk);
        #1;

        // Reset defaults
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_coef_ack", 32'(coef_ack), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        @(posedge aud_bclk); #1;

        // Pass-through with reset coefficients: 0x4000*0x7FFF rounds back to 0x4000
        send(1'b0, 16'h4000, 1'b1, 16'h4000, 1'b0);
        drain();

        // c[k]=k+1, impulse 0x7FFF: output n is round(0x7FFF*(n+1)/2^15) = n+1, then 0
        do_reset();
        for (int k = 0; k < int'(TAPS); k++) write_coef(5'(k), 16'(k + 1));
        send(1'b0, 16'h7FFF, 1'b1, 16'd1, 1'b0);
        for (int i = 1; i < int'(TAPS); i++) send(1'b0, 16'h0000, 1'b1, 16'(i + 1), 1'b0);
        send(1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0);
        drain();

        // All c=0x7FFF: first sample 0x7FFE, then positive clip; ch1 with 0x8000: 0x8001, then negative clip
        for (int k = 0; k < int'(TAPS); k++) write_coef(5'(k), 16'h7FFF);
        send(1'b0, 16'h7FFF, 1'b1, 16'h7FFE, 1'b0);
        for (int i = 1; i < int'(TAPS); i++) send(1'b0, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1);
        send(1'b1, 16'h8000, 1'b1, 16'h8001, 1'b0);
        for (int i = 1; i < int'(TAPS); i++) send(1'b1, 16'h8000, 1'b1, 16'h8000, 1'b1);
        drain();

        // Interleaved channels: ch0 impulse sequence must be untouched by ch1 zeros
        do_reset();
        for (int k = 0; k < int'(TAPS); k++) write_coef(5'(k), 16'(k + 1));
        for (int i = 0; i < int'(TAPS); i++) begin
            send(1'b0, (i == 0) ? 16'h7FFF : 16'h0000, 1'b1, 16'(i + 1), 1'b0);
            send(1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0);
        end
        drain();

        // Overrun and busy coefficient write; c[1]=0.5 exposes any history corruption
        do_reset();
        write_coef(5'd1, 16'h4000);
        send(1'b0, 16'h4000, 1'b1, 16'h4000, 1'b0);
        repeat (4) @(posedge aud_bclk);
        #1;
        in_valid   = 1'b1;
        in_ch      = 1'b0;
        in_data    = 16'h1234;
        coef_we    = 1'b1;
        coef_addr  = 5'd0;
        coef_wdata = 16'h1111;
        @(posedge aud_bclk); #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        chk("overrun_pulse", 32'(overrun), 32'd1);
        chk("busy_no_ack", 32'(coef_ack), 32'd0);
        @(posedge aud_bclk); #1;
        chk("overrun_one_cycle", 32'(overrun), 32'd0);
        chk("busy_no_ack_late", 32'(coef_ack), 32'd0);
        // 0x2000*0x7FFF + 0x4000*0x4000, rounded >>15 = 0x4000
        send(1'b0, 16'h2000, 1'b1, 16'h4000, 1'b0);
        drain();

        // Reset in the middle of MAC: no result, ready restored, histories cleared
        send(1'b0, 16'h4000, 1'b0, 16'h0000, 1'b0);
        repeat (10) @(posedge aud_bclk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge aud_bclk); #1;
        rst_n = 1'b1;
        repeat (TAPS + 4) @(posedge aud_bclk);
        #1;
        for (int k = 1; k < 4; k++) write_coef(5'(k), 16'h7FFF);
        send(1'b0, 16'h4000, 1'b1, 16'h4000, 1'b0);
        drain();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_tdm_filter.md
Name: fir_tdm_filter

Overview:
Parametrised, time-multiplexed successor to the fully parallel 32-tap audio FIR. It uses one signed multiply-accumulate unit that iterates over TAPS coefficients per sample, keeps an independent sample history per channel, and accepts coefficients written at run time. The output is rounded and saturated to the codec sample width. It sits between the WM8978 receive path (adc_data/rx_done) and downstream effect/FFT blocks, all in the aud_bclk domain.

Parameters:
DATA_W, 16, signed input sample width (two's complement)
COEF_W, 16, signed coefficient width (Q1.(COEF_W-1))
TAPS, 32, filter length; any value >=2, not required to be a power of two
CHANNELS, 2, independent sample histories (0=left, 1=right)
OUT_W, 16, signed output width
SHIFT, 15, right shift applied to the accumulator before saturation

Ports:
aud_bclk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
in_valid  in  1  sample strobe (driven from rx_done)
in_ch  in  clog2(CHANNELS) max 1  channel of the incoming sample
in_data  in  DATA_W  signed sample
in_ready  out  1  high when a sample can be accepted
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(TAPS)  tap index
coef_wdata  in  COEF_W  signed coefficient
coef_ack  out  1  one-cycle pulse, cycle after an accepted write
out_valid  out  1  one-cycle result strobe
out_ch  out  clog2(CHANNELS) max 1  channel of the result
out_data  out  OUT_W  signed filtered sample
out_sat  out  1  result was clipped; qualified by out_valid
overrun  out  1  one-cycle pulse when in_valid arrives while in_ready=0

Behaviour:
- Reset, asynchronous: FSM=IDLE; all histories=0; write pointers=0; accumulator=0.
- Reset coefficients: c[0]=2^(COEF_W-1)-1; all others 0 (near-unity pass-through).
- Reset outputs: in_ready=1, out_valid=0, out_ch=0, out_data=0, out_sat=0, coef_ack=0, overrun=0.
- A reset mid-operation abandons the sample in flight; no out_valid is produced for it.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - in_valid=1 accepts the sample: hist[in_ch][wptr[in_ch]] <= in_data.
  - The channel is latched, wptr advances mod TAPS, tap counter k=0, accumulator cleared, in_ready drops; next state MAC.
- MAC, one tap per cycle for exactly TAPS cycles:
  - acc += hist[ch][(newest - k) mod TAPS] * c[k], as a full-precision signed product.
  - Wrap is handled by compare/subtract, not masking.
  - After k=TAPS-1, next state DONE.
- Accumulator width: DATA_W+COEF_W+clog2(TAPS). Overflow is impossible by construction.
- DONE:
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 if clipped.
  - Register out_data/out_ch/out_sat; return to IDLE.
- Latency: with acceptance on edge 0, out_valid is high for exactly one cycle at edge TAPS+2. in_ready returns high on that same cycle.
- out_data/out_ch/out_sat hold their values until the next result.
- in_valid while in_ready=0: sample dropped, history untouched, overrun pulses for one cycle.
- Coefficient writes are accepted only in IDLE with no simultaneous in_valid accept; coef_ack follows one cycle later.
- A write at the same edge as a sample accept is ignored, with no ack, and has no effect. Writes while busy are likewise ignored; the software master retries until ack.
- coef_addr >= TAPS: write ignored, no ack.
- Channels are fully independent; a sample on one channel never alters another channel's history or pointer.

Decomposition:
- Shared package fir_pkg:
  - width constants: ACC_W derivation, clog2 helper
  - FSM state enum
  - round_sat function (acc, SHIFT, OUT_W -> data, sat flag)
  - default coefficient constant
- One sub-module: fir_mac_unit, a signed multiply-accumulate register with synchronous clear and enable. It is isolated so it can map to a DSP block.

Test Plan:
- Reset defaults, then ch0 sample 0x4000 -> out_valid at accept+34 (TAPS=32), out_data=0x4000, out_ch=0, out_sat=0.
- Load c[k]=k+1 (32 writes, each acked); feed ch0 impulse 0x7FFF then 31 zeros -> outputs 1,2,...,32, then a 33rd zero sample -> 0.
- Set all c[k]=0x7FFF; feed 32 x 0x7FFF -> last out_data=0x7FFF with out_sat=1. Repeat with 0x8000 -> 0x8000, out_sat=1.
- Interleave ch0 impulse 0x7FFF with ch1 constant 0 (c[k]=k+1) -> ch1 results all 0; ch0 sequence 1..32 unaffected.
- Fault cases:
  - in_valid pulsed 5 cycles after an accept -> overrun pulse; sample not filtered.
  - coef_we while busy -> no coef_ack; coefficient unchanged.
- Assert rst_n low during MAC cycle 10 -> no out_valid; histories=0; in_ready=1. Subsequent 0x4000 returns 0x4000.
